// File: rtl/triangle_setup_if.sv
// Triangle setup port bundle: the start/vertex request and the setup results.
// The master drives start and projected_verts; the slave (triangle_setup) drives the results.
interface triangle_setup_if #(
  parameter int COORD_WIDTH = 32
);
  logic                                    start;
  logic signed [2:0][3:0][COORD_WIDTH-1:0] projected_verts;
  logic [15:0]                             bbox_min_x;
  logic [15:0]                             bbox_max_x;
  logic [15:0]                             bbox_min_y;
  logic [15:0]                             bbox_max_y;
  logic signed [2:0][COORD_WIDTH-1:0]      edge_a;
  logic signed [2:0][COORD_WIDTH-1:0]      edge_b;
  logic signed [2:0][COORD_WIDTH-1:0]      edge_c;
  logic signed [COORD_WIDTH-1:0]           area2;
  logic                                    valid;
  logic                                    busy;
  logic                                    done;
  logic [1:0]                              status;

  modport master (
    output start, projected_verts,
    input  bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
    input  edge_a, edge_b, edge_c, area2, valid, busy, done, status
  );

  modport slave (
    input  start, projected_verts,
    output bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
    output edge_a, edge_b, edge_c, area2, valid, busy, done, status
  );
endinterface

// File: rtl/triangle_setup.sv
// Triangle setup: edge-function coefficients, doubled area, clamped bbox and accept/reject status.
// Optional macro BACKFACE_CULL_EN rejects negative-area triangles instead of flipping their winding.
module triangle_setup #(
  parameter int COORD_WIDTH = 32,
  parameter int FB_WIDTH    = 320,
  parameter int FB_HEIGHT   = 180
) (
  input  logic            clk_in,
  input  logic            rst_in,
  triangle_setup_if.slave tri_if
);
  localparam int W = COORD_WIDTH;
  localparam int H = COORD_WIDTH / 2;
  localparam logic signed [W-1:0] ZERO  = '0;
  localparam logic signed [W-1:0] X_MAX = W'(FB_WIDTH - 1);
  localparam logic signed [W-1:0] Y_MAX = W'(FB_HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, EDGE0, EDGE1, EDGE2, AREA, DONE} state_e;
  state_e state_q, state_d;

  logic signed [2:0][3:0][W-1:0] verts_q;
  logic signed [2:0][W-1:0]      edge_a_q, edge_b_q, edge_c_q;
  logic signed [W-1:0]           area2_q;
  logic [15:0]                   bbox_min_x_q, bbox_max_x_q, bbox_min_y_q, bbox_max_y_q;
  logic [1:0]                    status_q;
  logic                          valid_q;

  logic signed [W-1:0] px [3];
  logic signed [W-1:0] py [3];
  logic                unused_vert_bits;

  // Integer pixel position is the floor of the fixed-point value: the upper half, sign-extended.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_int
      assign px[gi] = {{H{verts_q[gi][0][W-1]}}, verts_q[gi][0][W-1:H]};
      assign py[gi] = {{H{verts_q[gi][1][W-1]}}, verts_q[gi][1][W-1:H]};
    end
  endgenerate

  assign unused_vert_bits = ^verts_q;

  // Edge stage: one edge per cycle through a pair of shared multipliers.
  logic [1:0]          ei, ej;
  logic                edge_en;
  logic signed [W-1:0] xi, yi, xj, yj, prod0, prod1;
  logic signed [W-1:0] a_val, b_val, c_val;

  always_comb begin
    edge_en = 1'b1;
    ei      = 2'd0;
    case (state_q)
      EDGE0:   ei = 2'd0;
      EDGE1:   ei = 2'd1;
      EDGE2:   ei = 2'd2;
      default: edge_en = 1'b0;
    endcase
    ej    = (ei == 2'd2) ? 2'd0 : ei + 2'd1;
    xi    = px[ei];
    yi    = py[ei];
    xj    = px[ej];
    yj    = py[ej];
    prod0 = xi * yj;
    prod1 = xj * yi;
    a_val = yi - yj;
    b_val = xj - xi;
    c_val = prod0 - prod1;
  end

  // Area stage: area, bounding box and classification, all registered on leaving AREA.
  logic signed [W-1:0] area_sum, min_x, max_x, min_y, max_y;
  logic [1:0]          status_d;
  logic                flip;

  function automatic logic [15:0] clamp16(input logic signed [W-1:0] v,
                                          input logic signed [W-1:0] hi);
    logic signed [W-1:0] r;
    r = v;
    if (v < ZERO)    r = ZERO;
    else if (v > hi) r = hi;
    return 16'(r);
  endfunction

  always_comb begin
    area_sum = edge_c_q[0] + edge_c_q[1] + edge_c_q[2];
    min_x = px[0];
    max_x = px[0];
    min_y = py[0];
    max_y = py[0];
    for (int k = 1; k < 3; k++) begin
      if (px[k] < min_x) min_x = px[k];
      if (px[k] > max_x) max_x = px[k];
      if (py[k] < min_y) min_y = py[k];
      if (py[k] > max_y) max_y = py[k];
    end
    if (area_sum == ZERO)
      status_d = 2'b10;
    else if (max_x < ZERO || min_x > X_MAX || max_y < ZERO || min_y > Y_MAX)
      status_d = 2'b11;
`ifdef BACKFACE_CULL_EN
    else if (area_sum < ZERO)
      status_d = 2'b01;
`endif
    else
      status_d = 2'b00;
`ifdef BACKFACE_CULL_EN
    flip = 1'b0;
`else
    flip = (area_sum < ZERO);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tri_if.start) state_d = LOAD;
      LOAD:    state_d = EDGE0;
      EDGE0:   state_d = EDGE1;
      EDGE1:   state_d = EDGE2;
      EDGE2:   state_d = AREA;
      AREA:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      verts_q      <= '0;
      edge_a_q     <= '0;
      edge_b_q     <= '0;
      edge_c_q     <= '0;
      area2_q      <= '0;
      bbox_min_x_q <= '0;
      bbox_max_x_q <= '0;
      bbox_min_y_q <= '0;
      bbox_max_y_q <= '0;
      status_q     <= 2'b00;
      valid_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && tri_if.start) begin
        verts_q <= tri_if.projected_verts;
        valid_q <= 1'b0;
      end
      if (edge_en) begin
        edge_a_q[ei] <= a_val;
        edge_b_q[ei] <= b_val;
        edge_c_q[ei] <= c_val;
      end
      if (state_q == AREA) begin
        area2_q      <= flip ? -area_sum : area_sum;
        bbox_min_x_q <= clamp16(min_x, X_MAX);
        bbox_max_x_q <= clamp16(max_x, X_MAX);
        bbox_min_y_q <= clamp16(min_y, Y_MAX);
        bbox_max_y_q <= clamp16(max_y, Y_MAX);
        status_q     <= status_d;
        valid_q      <= (status_d == 2'b00);
        if (flip) begin
          for (int k = 0; k < 3; k++) begin
            edge_a_q[k] <= -edge_a_q[k];
            edge_b_q[k] <= -edge_b_q[k];
            edge_c_q[k] <= -edge_c_q[k];
          end
        end
      end
    end
  end

  assign tri_if.busy       = (state_q != IDLE);
  assign tri_if.done       = (state_q == DONE);
  assign tri_if.valid      = valid_q;
  assign tri_if.status     = status_q;
  assign tri_if.area2      = area2_q;
  assign tri_if.edge_a     = edge_a_q;
  assign tri_if.edge_b     = edge_b_q;
  assign tri_if.edge_c     = edge_c_q;
  assign tri_if.bbox_min_x = bbox_min_x_q;
  assign tri_if.bbox_max_x = bbox_max_x_q;
  assign tri_if.bbox_min_y = bbox_min_y_q;
  assign tri_if.bbox_max_y = bbox_max_y_q;
endmodule

// File: tb/tb_triangle_setup.sv
// Self-checking bench for triangle_setup: directed corner triangles plus random ones
// against an arithmetic reference model of the setup rules.
module tb_triangle_setup;
  localparam int W   = 32;
  localparam int H   = 16;
  localparam int FBW = 320;
  localparam int FBH = 180;
`ifdef BACKFACE_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  triangle_setup_if #(.COORD_WIDTH(W)) tif ();

  triangle_setup #(.COORD_WIDTH(W), .FB_WIDTH(FBW), .FB_HEIGHT(FBH)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .tri_if (tif)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  int vx[3], vy[3];
  int exp_a[3], exp_b[3], exp_c[3];
  int exp_area, exp_minx, exp_maxx, exp_miny, exp_maxy, exp_status, exp_valid;

  task automatic check(input string tag, input longint obs, input longint expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Reference model: edge functions, doubled area, bbox and classification from plain integers.
  task automatic set_model(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
    int area, mnx, mxx, mny, mxy;
    vx = '{x0, x1, x2};
    vy = '{y0, y1, y2};
    area = 0;
    for (int i = 0; i < 3; i++) begin
      int j;
      j = (i + 1) % 3;
      exp_a[i] = vy[i] - vy[j];
      exp_b[i] = vx[j] - vx[i];
      exp_c[i] = vx[i] * vy[j] - vx[j] * vy[i];
      area += exp_c[i];
    end
    mnx = vx[0]; mxx = vx[0]; mny = vy[0]; mxy = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < mnx) mnx = vx[i];
      if (vx[i] > mxx) mxx = vx[i];
      if (vy[i] < mny) mny = vy[i];
      if (vy[i] > mxy) mxy = vy[i];
    end
    exp_minx = clampi(mnx, FBW - 1);
    exp_maxx = clampi(mxx, FBW - 1);
    exp_miny = clampi(mny, FBH - 1);
    exp_maxy = clampi(mxy, FBH - 1);
    exp_area = area;
    if (area == 0)                                              exp_status = 2;
    else if (mxx < 0 || mnx > FBW - 1 || mxy < 0 || mny > FBH - 1) exp_status = 3;
    else if (area < 0 && CULL)                                  exp_status = 1;
    else                                                        exp_status = 0;
    exp_valid = (exp_status == 0) ? 1 : 0;
    if (area < 0 && !CULL) begin
      exp_area = -area;
      for (int i = 0; i < 3; i++) begin
        exp_a[i] = -exp_a[i];
        exp_b[i] = -exp_b[i];
        exp_c[i] = -exp_c[i];
      end
    end
  endtask

  // Fixed-point encoding with random fraction bits, so the floor must discard them.
  task automatic drive_bus(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
    int xs[3], ys[3];
    xs = '{x0, x1, x2};
    ys = '{y0, y1, y2};
    for (int v = 0; v < 3; v++) begin
      tif.projected_verts[v][0] = (xs[v] <<< H) + int'($urandom_range(0, 65535));
      tif.projected_verts[v][1] = (ys[v] <<< H) + int'($urandom_range(0, 65535));
      tif.projected_verts[v][2] = $urandom();
      tif.projected_verts[v][3] = $urandom();
    end
  endtask

  task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2);
    set_model(x0, y0, x1, y1, x2, y2);
    drive_bus(x0, y0, x1, y1, x2, y2);
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic check_results(input string tag);
    check({tag, " area2"}, tif.area2, exp_area);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s a%0d", tag, i), $signed(tif.edge_a[i]), exp_a[i]);
      check($sformatf("%s b%0d", tag, i), $signed(tif.edge_b[i]), exp_b[i]);
      check($sformatf("%s c%0d", tag, i), $signed(tif.edge_c[i]), exp_c[i]);
    end
    check({tag, " min_x"}, tif.bbox_min_x, exp_minx);
    check({tag, " max_x"}, tif.bbox_max_x, exp_maxx);
    check({tag, " min_y"}, tif.bbox_min_y, exp_miny);
    check({tag, " max_y"}, tif.bbox_max_y, exp_maxy);
    check({tag, " status"}, tif.status, exp_status);
    check({tag, " valid"}, tif.valid, exp_valid);
    $display("[TB] %s: area2=%0d status=%0d valid=%0d bbox=(%0d..%0d,%0d..%0d)", tag,
             tif.area2, tif.status, tif.valid, tif.bbox_min_x, tif.bbox_max_x,
             tif.bbox_min_y, tif.bbox_max_y);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, tif.busy, 0);
    check({tag, " done"}, tif.done, 0);
    check({tag, " valid"}, tif.valid, 0);
    check({tag, " status"}, tif.status, 0);
    check({tag, " area2"}, tif.area2, 0);
    check({tag, " bbox"}, {tif.bbox_min_x, tif.bbox_max_x, tif.bbox_min_y, tif.bbox_max_y}, 0);
    check({tag, " edge_a"}, (tif.edge_a == '0) ? 0 : 1, 0);
    check({tag, " edge_b"}, (tif.edge_b == '0) ? 0 : 1, 0);
    check({tag, " edge_c"}, (tif.edge_c == '0) ? 0 : 1, 0);
  endtask

  // Presents start for one cycle (called at a falling edge), optionally pokes start and
  // scrambled vertices while busy, then checks latency, results and the hand-back to idle.
  task automatic run_tri(input string tag, input bit poke);
    int lat;
    tif.start = 1'b1;
    @(negedge clk_in);
    tif.start = 1'b0;
    lat = 1;
    while (tif.done !== 1'b1 && lat < 20) begin
      if (poke && lat == 2) begin
        tif.start = 1'b1;
        drive_bus(rnd(-100, 450), rnd(-50, 250), rnd(-100, 450), rnd(-50, 250),
                  rnd(-100, 450), rnd(-50, 250));
      end
      if (poke && lat == 3) tif.start = 1'b0;
      @(negedge clk_in);
      lat++;
    end
    check({tag, " latency"}, lat, 6);
    check({tag, " done"}, tif.done, 1);
    check({tag, " busy in done"}, tif.busy, 1);
    check_results(tag);
    @(negedge clk_in);
    check({tag, " done falls"}, tif.done, 0);
    check({tag, " busy falls"}, tif.busy, 0);
    check({tag, " valid held"}, tif.valid, exp_valid);
    check({tag, " area2 held"}, tif.area2, exp_area);
  endtask

  initial begin
    int seen, lat, gap;
    tif.start = 1'b0;
    tif.projected_verts = '0;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_zero("in_reset");
    rst_in = 1'b0;
    @(negedge clk_in);
    check_zero("post_reset");

    set_tri(10, 10, 50, 10, 10, 40);
    run_tri("right_tri", 1'b0);
    check("right_tri area2 const", tif.area2, 1200);
    check("right_tri a0 const", $signed(tif.edge_a[0]), 0);
    check("right_tri bbox const", {tif.bbox_min_x, tif.bbox_max_x, tif.bbox_min_y, tif.bbox_max_y},
          {16'd10, 16'd50, 16'd10, 16'd40});

    set_tri(10, 10, 10, 40, 50, 10);
    run_tri("swapped", 1'b0);
`ifdef BACKFACE_CULL_EN
    check("swapped status const", tif.status, 1);
    check("swapped valid const", tif.valid, 0);
`else
    check("swapped area2 const", tif.area2, 1200);
    check("swapped valid const", tif.valid, 1);
`endif

    set_tri(0, 0, 5, 5, 10, 10);
    run_tri("collinear", 1'b0);
    check("collinear status const", tif.status, 2);

    set_tri(-20, -5, 400, 30, 100, 200);
    run_tri("clamped", 1'b0);
    check("clamped bbox const", {tif.bbox_min_x, tif.bbox_max_x, tif.bbox_min_y, tif.bbox_max_y},
          {16'd0, 16'd319, 16'd0, 16'd179});
    check("clamped valid const", tif.valid, 1);

    set_tri(330, 0, 340, 0, 335, 10);
    run_tri("offscreen", 1'b0);
    check("offscreen status const", tif.status, 3);

    for (int n = 0; n < 12; n++) begin
      set_tri(rnd(-100, 450), rnd(-50, 250), rnd(-100, 450), rnd(-50, 250),
              rnd(-100, 450), rnd(-50, 250));
      run_tri($sformatf("random%0d", n), n[0]);
    end

    // Reset while the third pipeline state (second edge) is active.
    set_tri(20, 20, 120, 30, 60, 90);
    tif.start = 1'b1;
    @(negedge clk_in);
    tif.start = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_zero("mid_reset");
    seen = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (tif.done === 1'b1) seen = 1;
    end
    check("mid_reset no done", seen, 0);
    set_tri(5, 5, 80, 15, 30, 70);
    run_tri("after_reset", 1'b0);

    // Start held high: new vertices on the bus while busy must not be picked up until re-accept.
    set_tri(15, 12, 90, 20, 40, 100);
    tif.start = 1'b1;
    @(negedge clk_in);
    drive_bus(200, 50, 100, 60, 150, 150);
    lat = 1;
    while (tif.done !== 1'b1 && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
    check("held1 latency", lat, 6);
    check_results("held1");
    @(negedge clk_in);
    gap = 1;
    while (tif.done !== 1'b1 && gap < 20) begin
      @(negedge clk_in);
      gap++;
    end
    check("held done spacing", gap, 7);
    set_model(200, 50, 100, 60, 150, 150);
    check_results("held2");
    tif.start = 1'b0;
    @(negedge clk_in);
    check("held end busy", tif.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
